seq_mac_unit: RTL and testbench

Sequential multiply-accumulate responder for the PID controller's start/done strobe handshake. It computes out_o = acc_i + a_i × b_i with a bit-serial shift-add datapath, one step per clock-divider tick, to keep area and switching activity low. The PID core drives the operands and the start strobe, then waits for the done strobe; this block is the responding end of that handshake.

---
 rtl/seq_mac_unit_if.sv | 29 ++
 rtl/seq_mac_unit.sv | 161 ++++++++++++++++
 tb/tb_seq_mac_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seq_mac_unit_if.sv
// seq_mac_unit_if: start/done strobe handshake between the PID core (master)
// and the sequential multiply-accumulate responder (slave).
//   MUL_Start_STRB_i  master -> slave  start request
//   a_i, b_i          master -> slave  operands (low N bits used, signed)
//   acc_i             master -> slave  signed 2N-bit addend
//   MUL_Done_STRB_o   slave -> master  one-cycle completion pulse
//   out_o             slave -> master  signed 2N-bit result
//   busy_o            slave -> master  operation in progress
interface seq_mac_unit_if #(
    parameter int N = 41
);
    logic             MUL_Start_STRB_i;
    logic [2*N-1:0]   a_i;
    logic [2*N-1:0]   b_i;
    logic [2*N-1:0]   acc_i;
    logic             MUL_Done_STRB_o;
    logic [2*N-1:0]   out_o;
    logic             busy_o;

    modport master (
        output MUL_Start_STRB_i, a_i, b_i, acc_i,
        input  MUL_Done_STRB_o, out_o, busy_o
    );

    modport slave (
        input  MUL_Start_STRB_i, a_i, b_i, acc_i,
        output MUL_Done_STRB_o, out_o, busy_o
    );
endinterface

// File: rtl/seq_mac_unit.sv
// seq_mac_unit: bit-serial signed multiply-accumulate, out = acc + a*b.
// One shift-add step is taken every CLK_DIV_MULTIPLIER clocks; N steps are
// followed by one FINISH cycle that applies the sign and adds the addend.
// Ports:
//   clk_i  system clock
//   rst_i  asynchronous active-high reset
//   bus    seq_mac_unit_if slave modport (start/operands in, done/result/busy out)
module seq_mac_unit #(
    parameter int N                  = 41,
    parameter int CLK_DIV_MULTIPLIER = 50
) (
    input  logic          clk_i,
    input  logic          rst_i,
    seq_mac_unit_if.slave bus
);

    localparam int W  = 2 * N;
    localparam int SW = $clog2(N + 1);
    localparam int DW = (CLK_DIV_MULTIPLIER > 1) ? $clog2(CLK_DIV_MULTIPLIER) : 1;

    localparam logic [N-1:0]  N_ONE     = N'(1);
    localparam logic [W-1:0]  W_ONE     = W'(1);
    localparam logic [SW-1:0] STEP_ONE  = SW'(1);
    localparam logic [SW-1:0] LAST_STEP = SW'(N - 1);
    localparam logic [DW-1:0] DIV_ONE   = DW'(1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV_MULTIPLIER - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Two's-complement magnitude; -2^(N-1) maps to 2^(N-1), which still fits
    // in N unsigned bits.
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] v);
        if (v[N-1]) begin
            magnitude = ~v + N_ONE;
        end else begin
            magnitude = v;
        end
    endfunction

    state_t        state_q,  state_d;
    logic [W-1:0]  mcand_q,  mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic [W-1:0]  prod_q,   prod_d;
    logic [W-1:0]  acc_q,    acc_d;
    logic          sign_q,   sign_d;
    logic [SW-1:0] step_q,   step_d;
    logic [DW-1:0] div_q,    div_d;
    logic [W-1:0]  out_q,    out_d;
    logic          done_q,   done_d;
    logic          busy_q,   busy_d;

    logic [N-1:0]  a_n_s;
    logic [N-1:0]  b_n_s;
    logic          unused_upper_s;

    assign a_n_s = bus.a_i[N-1:0];
    assign b_n_s = bus.b_i[N-1:0];
    // Upper operand bits are deliberately ignored.
    assign unused_upper_s = ^{bus.a_i[W-1:N], bus.b_i[W-1:N]};

    // Next-state and datapath logic for the IDLE/RUN/FINISH sequencer.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        step_d   = step_q;
        div_d    = div_q;
        out_d    = out_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.MUL_Start_STRB_i) begin
                    state_d  = RUN;
                    mcand_d  = {{N{1'b0}}, magnitude(a_n_s)};
                    mplier_d = magnitude(b_n_s);
                    sign_d   = a_n_s[N-1] ^ b_n_s[N-1];
                    acc_d    = bus.acc_i;
                    prod_d   = {W{1'b0}};
                    step_d   = {SW{1'b0}};
                    div_d    = {DW{1'b0}};
                    busy_d   = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d = {DW{1'b0}};
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end else begin
                        prod_d = prod_q;
                    end
                    mcand_d  = {mcand_q[W-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[N-1:1]};
                    step_d   = step_q + STEP_ONE;
                    if (step_q == LAST_STEP) begin
                        state_d = FINISH;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            FINISH: begin
                // Modulo-2^(2N) result; any saturation is done downstream.
                out_d   = acc_q + (sign_q ? (~prod_q + W_ONE) : prod_q);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            mcand_q  <= {W{1'b0}};
            mplier_q <= {N{1'b0}};
            prod_q   <= {W{1'b0}};
            acc_q    <= {W{1'b0}};
            sign_q   <= 1'b0;
            step_q   <= {SW{1'b0}};
            div_q    <= {DW{1'b0}};
            out_q    <= {W{1'b0}};
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
            step_q   <= step_d;
            div_q    <= div_d;
            out_q    <= out_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.out_o           = out_q;
    assign bus.MUL_Done_STRB_o = done_q;
    assign bus.busy_o          = busy_q;

endmodule

// File: tb/tb_seq_mac_unit.sv
// tb_seq_mac_unit: directed bench for seq_mac_unit with three instances:
// A (N=8, div 1), B (N=8, div 3) and C (defaults N=41, div 50).
module tb_seq_mac_unit;

    logic clk;
    logic rst;

    logic        start_v [3];
    logic [81:0] a_v     [3];
    logic [81:0] b_v     [3];
    logic [81:0] acc_v   [3];
    logic        done_v  [3];
    logic        busy_v  [3];
    logic [81:0] out_v   [3];

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    seq_mac_unit_if #(.N(8))  if_a ();
    seq_mac_unit_if #(.N(8))  if_b ();
    seq_mac_unit_if #(.N(41)) if_c ();

    assign if_a.MUL_Start_STRB_i = start_v[0];
    assign if_a.a_i              = a_v[0][15:0];
    assign if_a.b_i              = b_v[0][15:0];
    assign if_a.acc_i            = acc_v[0][15:0];
    assign done_v[0]             = if_a.MUL_Done_STRB_o;
    assign busy_v[0]             = if_a.busy_o;
    assign out_v[0]              = {66'd0, if_a.out_o};

    assign if_b.MUL_Start_STRB_i = start_v[1];
    assign if_b.a_i              = a_v[1][15:0];
    assign if_b.b_i              = b_v[1][15:0];
    assign if_b.acc_i            = acc_v[1][15:0];
    assign done_v[1]             = if_b.MUL_Done_STRB_o;
    assign busy_v[1]             = if_b.busy_o;
    assign out_v[1]              = {66'd0, if_b.out_o};

    assign if_c.MUL_Start_STRB_i = start_v[2];
    assign if_c.a_i              = a_v[2];
    assign if_c.b_i              = b_v[2];
    assign if_c.acc_i            = acc_v[2];
    assign done_v[2]             = if_c.MUL_Done_STRB_o;
    assign busy_v[2]             = if_c.busy_o;
    assign out_v[2]              = if_c.out_o;

    seq_mac_unit #(.N(8), .CLK_DIV_MULTIPLIER(1)) dut_a (
        .clk_i (clk), .rst_i (rst), .bus (if_a)
    );
    seq_mac_unit #(.N(8), .CLK_DIV_MULTIPLIER(3)) dut_b (
        .clk_i (clk), .rst_i (rst), .bus (if_b)
    );
    seq_mac_unit dut_c (
        .clk_i (clk), .rst_i (rst), .bus (if_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [81:0] obs, input logic [81:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation on instance k and check result, latency and busy width.
    // poke re-asserts start at clock 4 of the run; tail checks no further done.
    task automatic run_op(input int k, input logic [81:0] a, input logic [81:0] b,
                          input logic [81:0] acc, input logic [81:0] exp,
                          input int exp_lat, input bit poke, input bit tail,
                          input string tag);
        int lat;
        int busyc;
        int extra;
        logic [81:0] mask;
        mask = (k == 2) ? {82{1'b1}} : 82'hFFFF;
        a_v[k]     = a;
        b_v[k]     = b;
        acc_v[k]   = acc;
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        check({tag, "_busy_start"}, {81'd0, busy_v[k]}, 82'd1);
        check({tag, "_done_start"}, {81'd0, done_v[k]}, 82'd0);
        lat   = 0;
        busyc = 1;
        while (!done_v[k] && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
            if (busy_v[k]) busyc++;
            if (lat == 3) begin
                a_v[k]   = ~a;
                b_v[k]   = ~b;
                acc_v[k] = ~acc;
            end
            if (poke && lat == 4) start_v[k] = 1'b1;
            if (poke && lat == 5) start_v[k] = 1'b0;
        end
        check({tag, "_latency"}, 82'(lat), 82'(exp_lat));
        check({tag, "_out"}, out_v[k] & mask, exp & mask);
        check({tag, "_busy_done"}, {81'd0, busy_v[k]}, 82'd0);
        check({tag, "_busy_cycles"}, 82'(busyc), 82'(exp_lat));
        if (tail) begin
            @(posedge clk); #1;
            check({tag, "_done_width"}, {81'd0, done_v[k]}, 82'd0);
            extra = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                if (done_v[k]) extra++;
            end
            check({tag, "_extra_done"}, 82'(extra), 82'd0);
        end
    endtask

    initial begin
        int extra;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            a_v[i]     = 82'd0;
            b_v[i]     = 82'd0;
            acc_v[i]   = 82'd0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_a",  out_v[0], 82'd0);
        check("rst_busy_a", {81'd0, busy_v[0]}, 82'd0);
        check("rst_done_a", {81'd0, done_v[0]}, 82'd0);
        check("rst_out_c",  out_v[2], 82'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 5*7 + 100 = 135
        run_op(0, 82'd5, 82'd7, 82'd100, 82'd135, 9, 1'b0, 1'b1, "basic");
        // (-128)*(-128) + 0 = 16384
        run_op(0, 82'h80, 82'h80, 82'd0, 82'h4000, 9, 1'b0, 1'b1, "minneg");
        // (-3)*7 + 10 = -11
        run_op(0, 82'hFD, 82'd7, 82'h000A, 82'hFFF5, 9, 1'b0, 1'b1, "negmix");
        // 32767 + 1*1 wraps to -32768; upper a_i bits 0xFF ignored
        run_op(1, 82'hFF01, 82'h0001, 82'h7FFF, 82'h8000, 25, 1'b0, 1'b1, "wrapdiv3");
        // 2^61 + 2^30 * (-2^30) = 2^60, inputs toggled mid-run
        run_op(2, 82'h0_4000_0000, 82'h1FF_C000_0000, 82'h2000_0000_0000_0000,
               82'h1000_0000_0000_0000, 2051, 1'b0, 1'b1, "dflt");
        // start re-asserted while busy: ignored, one done only; (-1)(-1)+0x1234
        run_op(0, 82'hFF, 82'hFF, 82'h1234, 82'h1235, 9, 1'b1, 1'b1, "restart");
        // back-to-back: second start issued in the done cycle, result fed back
        run_op(0, 82'd12, 82'hFB, 82'd0, 82'hFFC4, 9, 1'b0, 1'b0, "b2b_1");
        run_op(0, 82'h7F, 82'h7F, 82'hFFC4, 82'h3EC5, 9, 1'b0, 1'b1, "b2b_2");

        // asynchronous reset in the middle of a run
        a_v[0]     = 82'd3;
        b_v[0]     = 82'd3;
        acc_v[0]   = 82'd0;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_out",  out_v[0], 82'd0);
        check("async_rst_busy", {81'd0, busy_v[0]}, 82'd0);
        check("async_rst_done", {81'd0, done_v[0]}, 82'd0);
        #2;
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done_v[0]) extra++;
        end
        check("aborted_no_done", 82'(extra), 82'd0);
        // 2*3 + 4 = 10 after recovery
        run_op(0, 82'd2, 82'd3, 82'd4, 82'd10, 9, 1'b0, 1'b1, "post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
